sha256_nonce_sched: RTL and testbench

SHA256_NONCE_SCHED -- requirements
Module: sha256_nonce_sched

---
 rtl/sha256_nonce_sched.sv | 212 +++++++++++++++++++++
 tb/tb_sha256_nonce_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sched.sv
`default_nettype none
// ============================================================================
// sha256_nonce_sched : sweeps a nonce range through an external SHA-256 engine
// Option macro: SHA256_NONCE_SCHED_CYCLE_CNT_EN builds the hash cycle counter
// Rev 1.0
// ============================================================================
module sha256_nonce_sched (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [607:0] hdr_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_end_i,
    input  logic [255:0] target_i,
    output logic         busy_o,
    output logic         found_o,
    output logic         done_o,
    output logic [31:0]  nonce_o,
    output logic [255:0] hash_o,
    output logic         eng_rstn_o,
    input  logic         eng_ready_i,
    output logic         eng_start_o,
    output logic         eng_dbl_hash_o,
    input  logic         eng_valid_i,
    input  logic [255:0] eng_hash_i,
    input  logic         fifo_full_i,
    output logic         fifo_wr_en_o,
    output logic [31:0]  fifo_wr_dat_o,
    output logic         dma_in_progress_o,
    output logic [31:0]  dbg_hash_cycles_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERST  = 3'd1,
        WRDY  = 3'd2,
        FILL  = 3'd3,
        HASH  = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           erst_cnt;
    logic [4:0]     word_idx;
    logic [31:0]    nonce;
    logic [255:0]   hash_cap;
    logic           busy;
    logic           found;
    logic           done;
    logic           eng_start;
    logic [31:0]    nonce_rec;
    logic [255:0]   hash_rec;

    logic           abort;
    logic           wr_fire;
    logic           hit;
    logic           last_nonce;
    logic [9:0]     hdr_base;
    logic [31:0]    fill_word;

    // DONE is excluded from abort so a finished job's result is never rewritten
    assign abort      = stop_i && (state != IDLE) && (state != DONE);
    assign wr_fire    = (state == FILL) && !fifo_full_i && !stop_i;
    assign hit        = (hash_cap <= target_i);
    assign last_nonce = (nonce == nonce_end_i);
    assign hdr_base   = {5'd18 - word_idx, 5'd0};

    always_comb begin
        fill_word = 32'd0;
        if (word_idx < 5'd19) begin
            fill_word = hdr_i[hdr_base +: 32];
        end else if (word_idx == 5'd19) begin
            fill_word = nonce;
        end else if (word_idx == 5'd20) begin
            fill_word = 32'h8000_0000;
        end else if (word_idx == 5'd31) begin
            fill_word = 32'h0000_0280;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ERST;
            ERST:    if (erst_cnt) state_nxt = WRDY;
            WRDY:    if (eng_ready_i) state_nxt = FILL;
            FILL:    if (wr_fire && (word_idx == 5'd31)) state_nxt = HASH;
            HASH:    if (eng_valid_i) state_nxt = CHECK;
            CHECK:   state_nxt = (hit || last_nonce) ? DONE : ERST;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            erst_cnt  <= 1'b0;
            word_idx  <= 5'd0;
            nonce     <= 32'd0;
            hash_cap  <= 256'd0;
            busy      <= 1'b0;
            found     <= 1'b0;
            done      <= 1'b0;
            eng_start <= 1'b0;
            nonce_rec <= 32'd0;
            hash_rec  <= 256'd0;
        end else begin
            erst_cnt <= (state == ERST) && !erst_cnt;

            if (state != FILL) begin
                word_idx <= 5'd0;
            end else if (wr_fire) begin
                word_idx <= word_idx + 5'd1;
            end

            if ((state == HASH) && eng_valid_i) begin
                hash_cap <= eng_hash_i;
            end

            if ((state == WRDY) && eng_ready_i) begin
                eng_start <= 1'b1;
            end else if ((state == HASH) && eng_valid_i) begin
                eng_start <= 1'b0;
            end

            if ((state == IDLE) && start_i) begin
                nonce <= nonce_start_i;
                found <= 1'b0;
                done  <= 1'b0;
                busy  <= 1'b1;
            end

            if (state == CHECK) begin
                if (hit || last_nonce) begin
                    found     <= hit;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    nonce_rec <= nonce;
                    hash_rec  <= hash_cap;
                end else begin
                    nonce <= nonce + 32'd1;
                end
            end

            // Placed last so it overrides the CHECK result in the same cycle
            if (abort) begin
                found     <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                eng_start <= 1'b0;
                nonce     <= nonce;
                nonce_rec <= nonce_rec;
                hash_rec  <= hash_rec;
            end
        end
    end

`ifdef SHA256_NONCE_SCHED_CYCLE_CNT_EN
    logic [31:0] hash_cycles;
    logic [31:0] dbg_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hash_cycles <= 32'd0;
            dbg_cycles  <= 32'd0;
        end else begin
            if ((state_nxt == ERST) && (state != ERST)) begin
                hash_cycles <= 32'd0;
            end else if (((state == ERST) || (state == WRDY) || (state == FILL) ||
                          (state == HASH)) && (hash_cycles != 32'hFFFF_FFFF)) begin
                hash_cycles <= hash_cycles + 32'd1;
            end
            if (state == CHECK) begin
                dbg_cycles <= hash_cycles;
            end
        end
    end

    assign dbg_hash_cycles_o = dbg_cycles;
`else
    assign dbg_hash_cycles_o = 32'd0;
`endif

    assign busy_o            = busy;
    assign found_o           = found;
    assign done_o            = done;
    assign nonce_o           = nonce_rec;
    assign hash_o            = hash_rec;
    assign eng_rstn_o        = (state == WRDY) || (state == FILL) ||
                               (state == HASH) || (state == CHECK);
    assign eng_start_o       = eng_start;
    assign eng_dbl_hash_o    = 1'b1;
    assign fifo_wr_en_o      = wr_fire;
    assign fifo_wr_dat_o     = (state == FILL) ? fill_word : 32'd0;
    assign dma_in_progress_o = (state == FILL);

endmodule
`default_nettype wire

// File: tb/tb_sha256_nonce_sched.sv
`default_nettype none
// ============================================================================
// tb_sha256_nonce_sched : randomized bench with engine model and nonce-sweep reference
// Rev 1.0
// ============================================================================
module tb_sha256_nonce_sched;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         stop_i;
    logic [607:0] hdr_i;
    logic [31:0]  nonce_start_i;
    logic [31:0]  nonce_end_i;
    logic [255:0] target_i;
    logic         busy_o;
    logic         found_o;
    logic         done_o;
    logic [31:0]  nonce_o;
    logic [255:0] hash_o;
    logic         eng_rstn_o;
    logic         eng_ready_i;
    logic         eng_start_o;
    logic         eng_dbl_hash_o;
    logic         eng_valid_i;
    logic [255:0] eng_hash_i;
    logic         fifo_full_i;
    logic         fifo_wr_en_o;
    logic [31:0]  fifo_wr_dat_o;
    logic         dma_in_progress_o;
    logic [31:0]  dbg_hash_cycles_o;

    int checks = 0;
    int errors = 0;
    bit hit_en;
    logic [31:0] hit_nonce;

    sha256_nonce_sched dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .hdr_i(hdr_i), .nonce_start_i(nonce_start_i), .nonce_end_i(nonce_end_i),
        .target_i(target_i), .busy_o(busy_o), .found_o(found_o), .done_o(done_o),
        .nonce_o(nonce_o), .hash_o(hash_o), .eng_rstn_o(eng_rstn_o),
        .eng_ready_i(eng_ready_i), .eng_start_o(eng_start_o),
        .eng_dbl_hash_o(eng_dbl_hash_o), .eng_valid_i(eng_valid_i),
        .eng_hash_i(eng_hash_i), .fifo_full_i(fifo_full_i),
        .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_dat_o(fifo_wr_dat_o),
        .dma_in_progress_o(dma_in_progress_o), .dbg_hash_cycles_o(dbg_hash_cycles_o)
    );

    always #4 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Engine hash model: a hit nonce yields a tiny hash, everything else is >= 2^255
    function automatic logic [255:0] hashf(input logic [31:0] n);
        logic [31:0] m;
        m = n * 32'h9E37_79B9;
        if (hit_en && (n == hit_nonce)) return {32'h0000_0001, {7{m}}};
        return {32'h8000_0000 | m, {7{~m}}};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {busy_o, found_o, done_o, eng_start_o, fifo_wr_en_o,
                               dma_in_progress_o, eng_rstn_o}, 0);
        check({tag, "_nonce"}, nonce_o, 0);
        check({tag, "_hash"}, hash_o, 0);
        check({tag, "_wrdat"}, fifo_wr_dat_o, 0);
        check({tag, "_dbg"}, dbg_hash_cycles_o, 0);
    endtask

    task automatic new_hdr();
        for (int i = 0; i < 19; i++) hdr_i[32*i +: 32] = $urandom;
    endtask

    // mode 0: normal job; mode 1: assert rst_i while the engine is hashing
    task automatic run_job(input string name, input logic [31:0] ns, input logic [31:0] ne,
                           input logic [255:0] tgt, input int full_mode, input int stop_at,
                           input bit try_done, input int mode);
        logic [31:0] exp_n[$];
        logic [31:0] got_n[$];
        logic [31:0] msg[$];
        logic [31:0] n;
        logic [31:0] msg_nonce = 32'd0;
        bit exp_found = 1'b0;
        int cyc = 0, low_run = 0, pulses = 0, bad_pulse = 0, bad_wr = 0;
        int words_total = 0, eng_words = 0, eng_lat = -1, rdy_cnt = 0, hw = 0;
        int post_stop = 0, rst_wr = 0;
        int rdy_lat;
        bit seen_busy = 1'b0, fin = 1'b0, stopped = 1'b0;

        n = ns;
        for (int k = 0; k < 64; k++) begin
            exp_n.push_back(n);
            if (hashf(n) <= tgt) begin
                exp_found = 1'b1;
                break;
            end
            if (n == ne) break;
            n = n + 32'd1;
        end
        rdy_lat = $urandom_range(0, 3);

        nonce_start_i = ns;
        nonce_end_i   = ne;
        target_i      = tgt;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;

        while (!fin && cyc < 4000) begin
            cyc++;
            case (full_mode)
                0:       fifo_full_i = 1'b0;
                1:       fifo_full_i = (cyc % 2 == 1);
                default: fifo_full_i = ($urandom_range(0, 2) == 0);
            endcase
            eng_ready_i = eng_rstn_o && (rdy_cnt >= rdy_lat);
            eng_valid_i = 1'b0;
            if (eng_lat == 0) begin
                eng_valid_i = 1'b1;
                eng_hash_i  = hashf(msg_nonce);
                eng_lat     = -1;
            end else if (eng_lat > 0) begin
                eng_lat--;
            end
            stop_i = 1'b0;
            if (stop_at >= 0 && !stopped && dma_in_progress_o && eng_words == stop_at) begin
                stop_i  = 1'b1;
                stopped = 1'b1;
            end
            #1;
            if (fifo_full_i && fifo_wr_en_o) bad_wr++;
            if (dma_in_progress_o && !fifo_wr_en_o && eng_words >= 32) bad_wr++;
            if (fifo_wr_en_o) begin
                if (stopped) post_stop++;
                if (!dma_in_progress_o) bad_wr++;
                msg.push_back(fifo_wr_dat_o);
                words_total++;
                eng_words++;
                if (eng_words == 32) begin
                    for (int i = 0; i < 32; i++) begin
                        logic [31:0] ew;
                        if (i < 19) ew = hdr_i[607 - 32*i -: 32];
                        else if (i == 19) ew = (got_n.size() < exp_n.size()) ? exp_n[got_n.size()] : 32'hx;
                        else if (i == 20) ew = 32'h8000_0000;
                        else if (i == 31) ew = 32'h0000_0280;
                        else ew = 32'd0;
                        check($sformatf("%s_m%0d_w%0d", name, got_n.size(), i), msg[i], ew);
                    end
                    msg_nonce = msg[19];
                    got_n.push_back(msg[19]);
                    msg.delete();
                    if (mode == 0) eng_lat = $urandom_range(0, 4);
                end
            end
            if (busy_o) begin
                seen_busy = 1'b1;
                if (!eng_rstn_o) begin
                    low_run++;
                end else if (low_run > 0) begin
                    pulses++;
                    if (low_run != 2) bad_pulse++;
                    low_run = 0;
                end
            end
            if (!eng_rstn_o) begin
                eng_words = 0;
                eng_lat   = -1;
                rdy_cnt   = 0;
            end else begin
                rdy_cnt++;
            end
            if (mode == 1 && eng_words == 32) begin
                hw++;
                if (hw == 3) begin
                    check({name, "_in_hash"}, {eng_start_o, dma_in_progress_o, busy_o}, 3'b101);
                    #1 rst_i = 1'b1;
                    #1;
                    check_reset_outputs({name, "_async"});
                    @(negedge clk_i);
                    rst_i = 1'b0;
                    fifo_full_i = 1'b0;
                    eng_ready_i = 1'b1;
                    repeat (40) begin
                        #1;
                        if (fifo_wr_en_o || busy_o) rst_wr++;
                        @(negedge clk_i);
                    end
                    check({name, "_no_writes_after"}, rst_wr, 0);
                    return;
                end
            end
            if (seen_busy && !busy_o) fin = 1'b1;
            if (!fin) @(negedge clk_i);
        end

        check({name, "_finished"}, fin, 1'b1);
        check({name, "_done"}, done_o, 1'b1);
        check({name, "_rstn_in_done"}, {eng_rstn_o, eng_start_o, fifo_wr_en_o}, 3'b000);
        if (stop_at >= 0) begin
            check({name, "_abort_found"}, found_o, 1'b0);
            check({name, "_abort_words"}, words_total, stop_at);
            check({name, "_post_stop_writes"}, post_stop, 0);
            check({name, "_abort_pulses"}, pulses, 1);
        end else begin
            check({name, "_found"}, found_o, exp_found);
            check({name, "_nonce"}, nonce_o, exp_n[$]);
            check({name, "_hash"}, hash_o, hashf(exp_n[$]));
            check({name, "_msgs"}, got_n.size(), exp_n.size());
            for (int i = 0; i < got_n.size() && i < exp_n.size(); i++)
                check($sformatf("%s_tried%0d", name, i), got_n[i], exp_n[i]);
            check({name, "_rst_pulses"}, pulses, exp_n.size());
            check({name, "_words"}, words_total, 32 * exp_n.size());
        end
        check({name, "_pulse_len"}, bad_pulse, 0);
        check({name, "_wr_dma"}, bad_wr, 0);

        start_i = try_done;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        check({name, "_idle"}, {busy_o, done_o}, 2'b01);
    endtask

    initial begin
        logic [31:0] ns, ne, len;
        logic [255:0] tgt;
        rst_i = 1'b1;
        start_i = 1'b0;
        stop_i = 1'b0;
        fifo_full_i = 1'b0;
        eng_ready_i = 1'b0;
        eng_valid_i = 1'b0;
        eng_hash_i = '0;
        hdr_i = '0;
        nonce_start_i = '0;
        nonce_end_i = '0;
        target_i = '0;
        hit_en = 1'b0;
        hit_nonce = '0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("dbl_hash", eng_dbl_hash_o, 1'b1);

        new_hdr();
        run_job("single", 32'd5, 32'd5, '1, 0, -1, 1'b1, 0);
        new_hdr();
        run_job("miss", 32'd10, 32'd12, '0, 0, -1, 1'b0, 0);
        new_hdr();
        hit_en = 1'b1;
        hit_nonce = 32'd0;
        run_job("wrap", 32'hFFFF_FFFE, 32'd1, hashf(32'd0), 0, -1, 1'b0, 0);
        hit_en = 1'b0;
        new_hdr();
        ns = $urandom;
        run_job("backpressure", ns, ns + 32'd1, '0, 1, -1, 1'b0, 0);
        new_hdr();
        run_job("abort", 32'd20, 32'd30, '0, 0, 7, 1'b0, 0);
        new_hdr();
        hit_en = 1'b1;
        hit_nonce = 32'd41;
        run_job("after_abort", 32'd40, 32'd43, hashf(32'd41), 2, -1, 1'b0, 0);

        for (int j = 0; j < 8; j++) begin
            new_hdr();
            ns = $urandom;
            if ($urandom_range(0, 1) == 1) ns = 32'hFFFF_FFFF - $urandom_range(0, 2);
            len = $urandom_range(0, 3);
            ne = ns + len;
            hit_en = ($urandom_range(0, 1) == 1);
            hit_nonce = ns + $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       tgt = '1;
                1:       tgt = '0;
                2:       tgt = hashf(hit_nonce);
                default: tgt = hashf(hit_nonce) - 256'd1;
            endcase
            run_job($sformatf("rnd%0d", j), ns, ne, tgt, $urandom_range(0, 2), -1, 1'b1, 0);
        end

        hit_en = 1'b0;
        new_hdr();
        run_job("reset_mid_hash", 32'd100, 32'd101, '0, 0, -1, 1'b0, 1);
        new_hdr();
        run_job("after_reset", 32'd7, 32'd7, '1, 2, -1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
